// File: rtl/synth_sequencer.sv
// ---------------------------------------------------------------------------
// synth_sequencer
//   Plays a small loadable note table into the 32-bit `scale` input of the
//   phase-accumulator tone generator. Each entry is {scale, duration in
//   ticks}; a tick is TICK_DIV clk cycles. Notes play in table order with an
//   optional silent gap after each one, and the sequence may loop.
//
// Parameters
//   DEPTH_LOG2 : log2 of the number of table entries
//   TICK_DIV   : clk cycles per duration tick (>= 1)
//   GAP_TICKS  : silent ticks after each note (0 = no gap, <= 65535)
//
// Ports
//   clk       : system clock (PLL global clock)
//   rst       : synchronous active-high reset
//   wr_en     : note-table write strobe
//   wr_addr   : table entry to write
//   wr_scale  : scale value for the entry
//   wr_dur    : duration in ticks; 0 marks end of sequence
//   start     : begin playback from entry 0 (pulse, ignored while busy)
//   stop      : abort playback (pulse, wins over start)
//   loop      : sampled with start; 1 = wrap to entry 0 at marker/table end
//   scale     : registered scale to the synth; 0 = silence
//   busy      : high while a sequence is active
//   note_idx  : entry currently being loaded or played
//   done      : one-cycle pulse on natural end of the sequence
// ---------------------------------------------------------------------------
module synth_sequencer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TICK_DIV   = 1000,
    parameter int GAP_TICKS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [31:0]           wr_scale,
    input  logic [15:0]           wr_dur,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop,
    output logic [31:0]           scale,
    output logic                  busy,
    output logic [DEPTH_LOG2-1:0] note_idx,
    output logic                  done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]         PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [15:0]           GAP_LEN  = 16'(GAP_TICKS);
    localparam logic [DEPTH_LOG2-1:0] IDX_LAST = DEPTH_LOG2'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    state_t state, state_nxt;

    // Note table; contents survive reset.
    logic [31:0] tbl_scale [DEPTH];
    logic [15:0] tbl_dur   [DEPTH];

    logic [PW-1:0]         presc, presc_nxt;
    logic [15:0]           cnt, cnt_nxt;        // note ticks, then gap ticks
    logic [31:0]           note_scale, note_scale_nxt;
    logic                  loop_r, loop_nxt;
    logic [DEPTH_LOG2-1:0] idx_nxt;
    logic [31:0]           scale_nxt;
    logic                  done_nxt;
    logic                  advance;
    logic                  tick;
    logic [31:0]           rd_scale;
    logic [15:0]           rd_dur;

    // Asynchronous read: a write landing on the same edge as a LOAD only
    // becomes visible afterwards, so the LOAD sees the old contents.
    assign rd_scale = tbl_scale[note_idx];
    assign rd_dur   = tbl_dur[note_idx];
    assign tick     = (presc == PRE_MAX);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tbl_scale[wr_addr] <= wr_scale;
            tbl_dur[wr_addr]   <= wr_dur;
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = note_idx;
        cnt_nxt        = cnt;
        note_scale_nxt = note_scale;
        loop_nxt       = loop_r;
        presc_nxt      = '0;
        done_nxt       = 1'b0;
        advance        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    state_nxt = S_LOAD;
                    idx_nxt   = '0;
                    loop_nxt  = loop;
                end
            end
            S_LOAD: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (rd_dur != 16'd0) begin
                    note_scale_nxt = rd_scale;
                    cnt_nxt        = rd_dur;
                    state_nxt      = S_PLAY;
                end else if (loop_r && note_idx != '0) begin
                    // End marker while looping: reload entry 0 next cycle.
                    idx_nxt = '0;
                end else begin
                    // Marker at entry 0 while looping would spin forever;
                    // treat it as a natural end instead.
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else begin
                    presc_nxt = tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        cnt_nxt = cnt - 16'd1;
                        if (cnt == 16'd1) begin
                            if (GAP_TICKS > 0) begin
                                state_nxt = S_GAP;
                                cnt_nxt   = GAP_LEN;
                            end else begin
                                advance = 1'b1;
                            end
                        end
                    end
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else begin
                    presc_nxt = tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        cnt_nxt = cnt - 16'd1;
                        if (cnt == 16'd1) advance = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Step to the next entry once a note (and its gap) has finished.
        if (advance) begin
            if (note_idx != IDX_LAST) begin
                idx_nxt   = note_idx + 1'b1;
                state_nxt = S_LOAD;
            end else if (loop_r) begin
                idx_nxt   = '0;
                state_nxt = S_LOAD;
            end else begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end
        end

        // Output register follows the next state so scale changes exactly
        // on the state boundary; everything but PLAY is silent.
        scale_nxt = (state_nxt == S_PLAY) ? note_scale_nxt : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            scale      <= 32'd0;
            done       <= 1'b0;
            note_idx   <= '0;
            presc      <= '0;
            loop_r     <= 1'b0;
            cnt        <= 16'd0;
            note_scale <= 32'd0;
        end else begin
            state      <= state_nxt;
            scale      <= scale_nxt;
            done       <= done_nxt;
            note_idx   <= idx_nxt;
            presc      <= presc_nxt;
            loop_r     <= loop_nxt;
            cnt        <= cnt_nxt;
            note_scale <= note_scale_nxt;
        end
    end

endmodule

// File: tb/tb_synth_sequencer.sv
// ---------------------------------------------------------------------------
// tb_synth_sequencer
//   Two sequencers (GAP_TICKS=1 and GAP_TICKS=0, TICK_DIV=4) share one set of
//   inputs. A reference model expands the note table into the expected
//   per-cycle output trace after a start pulse; outputs are compared every
//   cycle, plus a checkpoint table and hand-written corner sequences.
// ---------------------------------------------------------------------------
module tb_synth_sequencer;

    localparam int TD    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, wr_en, start, stop, loop;
    logic [3:0]  wr_addr;
    logic [31:0] wr_scale;
    logic [15:0] wr_dur;

    logic [31:0] scale1, scale0;
    logic        busy1, busy0, done1, done0;
    logic [3:0]  idx1, idx0;

    synth_sequencer #(.DEPTH_LOG2(4), .TICK_DIV(TD), .GAP_TICKS(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_scale(wr_scale), .wr_dur(wr_dur), .start(start), .stop(stop),
        .loop(loop), .scale(scale1), .busy(busy1), .note_idx(idx1),
        .done(done1)
    );

    synth_sequencer #(.DEPTH_LOG2(4), .TICK_DIV(TD), .GAP_TICKS(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_scale(wr_scale), .wr_dur(wr_dur), .start(start), .stop(stop),
        .loop(loop), .scale(scale0), .busy(busy0), .note_idx(idx0),
        .done(done0)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] scale;
        bit          busy;
        bit          done;
        int          idx;    // -1: not checked
    } exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] scale;
        bit          busy;
        bit          done;
    } vec_t;

    exp_t        q1[$], q0[$], mq[$];
    logic [31:0] m_scale [DEPTH];
    int          m_dur   [DEPTH];
    bit          chk1 = 1'b1, chk0 = 1'b1;
    int          cyc;
    vec_t        vt[11];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(input logic [31:0] s, input bit b,
                                 input bit d, input int i);
        exp_t e;
        e.scale = s; e.busy = b; e.done = d; e.idx = i;
        mq.push_back(e);
    endfunction

    // Expected outputs for cycles 1,2,... after a start sampled at the end
    // of cycle 0, derived directly from the note table.
    function automatic void build(input bit lp, input int gap, input int cap);
        int idx = 0;
        bit fin = 1'b0;
        mq.delete();
        while (!fin && mq.size() < cap) begin
            push(32'h0, 1'b1, 1'b0, idx);                 // load cycle
            if (m_dur[idx] == 0) begin
                if (lp && idx != 0) idx = 0;
                else fin = 1'b1;
            end else begin
                for (int k = 0; k < m_dur[idx] * TD; k++)
                    push(m_scale[idx], 1'b1, 1'b0, idx);
                for (int k = 0; k < gap * TD; k++)
                    push(32'h0, 1'b1, 1'b0, idx);
                if (idx < DEPTH - 1) idx++;
                else if (lp) idx = 0;
                else fin = 1'b1;
            end
        end
        if (fin) begin
            push(32'h0, 1'b0, 1'b1, -1);
            push(32'h0, 1'b0, 1'b0, -1);
            push(32'h0, 1'b0, 1'b0, -1);
        end
    endfunction

    task automatic wr(input int a, input logic [31:0] s, input int d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_scale = s; wr_dur = 16'(d);
        step();
        wr_en = 1'b0;
        m_scale[a] = s;
        m_dur[a]   = d;
    endtask

    task automatic kick(input bit lp, input int cap);
        build(lp, 1, cap); q1 = mq;
        build(lp, 0, cap); q0 = mq;
        loop = lp; start = 1'b1;
        step();
        start = 1'b0; loop = 1'b0;
        cyc = 1;
    endtask

    task automatic cmp_cycle();
        exp_t e;
        if (chk1 && cyc - 1 < q1.size()) begin
            e = q1[cyc-1];
            check($sformatf("g1 c%0d scale", cyc), scale1, e.scale);
            check($sformatf("g1 c%0d busy", cyc), 32'(busy1), 32'(e.busy));
            check($sformatf("g1 c%0d done", cyc), 32'(done1), 32'(e.done));
            if (e.idx >= 0)
                check($sformatf("g1 c%0d idx", cyc), 32'(idx1), 32'(e.idx));
        end
        if (chk0 && cyc - 1 < q0.size()) begin
            e = q0[cyc-1];
            check($sformatf("g0 c%0d scale", cyc), scale0, e.scale);
            check($sformatf("g0 c%0d busy", cyc), 32'(busy0), 32'(e.busy));
            check($sformatf("g0 c%0d done", cyc), 32'(done0), 32'(e.done));
            if (e.idx >= 0)
                check($sformatf("g0 c%0d idx", cyc), 32'(idx0), 32'(e.idx));
        end
    endtask

    task automatic follow(input int n);
        for (int i = 0; i < n; i++) begin
            cmp_cycle();
            step();
            cyc++;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy1"}, 32'(busy1), 32'd0);
        check({tag, " busy0"}, 32'(busy0), 32'd0);
        check({tag, " scale1"}, scale1, 32'd0);
        check({tag, " scale0"}, scale0, 32'd0);
        check({tag, " done1"}, 32'(done1), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        wr_addr = '0; wr_scale = '0; wr_dur = '0;

        // Reset state.
        step(); step();
        check_idle("reset");
        check("reset idx1", 32'(idx1), 32'd0);
        check("reset idx0", 32'(idx0), 32'd0);
        check("reset done0", 32'(done0), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) wr(i, 32'h0, 0);

        // Scenario 1: plain sequence with checkpoints.
        wr(0, 32'h1000, 2);
        wr(1, 32'h2000, 3);
        wr(2, 32'h0, 0);
        vt[0]  = '{1,  32'h0,    1'b1, 1'b0};
        vt[1]  = '{2,  32'h1000, 1'b1, 1'b0};
        vt[2]  = '{9,  32'h1000, 1'b1, 1'b0};
        vt[3]  = '{10, 32'h0,    1'b1, 1'b0};
        vt[4]  = '{14, 32'h0,    1'b1, 1'b0};
        vt[5]  = '{15, 32'h2000, 1'b1, 1'b0};
        vt[6]  = '{26, 32'h2000, 1'b1, 1'b0};
        vt[7]  = '{27, 32'h0,    1'b1, 1'b0};
        vt[8]  = '{31, 32'h0,    1'b1, 1'b0};
        vt[9]  = '{32, 32'h0,    1'b0, 1'b1};
        vt[10] = '{33, 32'h0,    1'b0, 1'b0};
        kick(1'b0, 400);
        for (int c = 1; c <= 34; c++) begin
            cmp_cycle();
            foreach (vt[v]) begin
                if (vt[v].cyc == cyc) begin
                    check($sformatf("vec c%0d scale", cyc), scale1, vt[v].scale);
                    check($sformatf("vec c%0d busy", cyc), 32'(busy1), 32'(vt[v].busy));
                    check($sformatf("vec c%0d done", cyc), 32'(done1), 32'(vt[v].done));
                end
            end
            step();
            cyc++;
        end

        // Scenarios 2 and 5: loop, rewrite entry 0 while it plays, then stop.
        chk0 = 1'b0;
        kick(1'b1, 32);
        follow(4);
        wr_en = 1'b1; wr_addr = 4'd0; wr_scale = 32'h3000; wr_dur = 16'd2;
        follow(1);
        wr_en = 1'b0;
        m_scale[0] = 32'h3000;
        follow(27);
        for (int c = 0; c < 8; c++) begin
            check($sformatf("rewrite c%0d scale", cyc), scale1, 32'h3000);
            check($sformatf("rewrite c%0d busy", cyc), 32'(busy1), 32'd1);
            check($sformatf("rewrite c%0d done", cyc), 32'(done1), 32'd0);
            step();
            cyc++;
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_idle("stop");
        chk0 = 1'b1;
        wr(0, 32'h1000, 2);

        // Scenario 3: marker at entry 0 with loop ends immediately.
        wr(0, 32'h5555, 0);
        kick(1'b1, 20);
        follow(q1.size());
        wr(0, 32'h1000, 2);

        // Scenario 6: start+stop together stays idle.
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check_idle("startstop a");
        step();
        check_idle("startstop b");

        // Reset mid-play, then replay with the preserved table.
        kick(1'b0, 400);
        follow(4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("midrst");
        check("midrst idx1", 32'(idx1), 32'd0);
        kick(1'b0, 400);
        follow(q1.size());

        // Scenario 4: full table, one tick each, no loop.
        for (int i = 0; i < DEPTH; i++) wr(i, 32'(i + 1), 1);
        kick(1'b0, 400);
        follow(q1.size());

        // Randomized tables.
        for (int it = 0; it < 8; it++) begin
            bit lp;
            for (int i = 0; i < DEPTH; i++)
                wr(i, $urandom, ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3));
            lp = 1'($urandom_range(0, 1));
            kick(lp, 150);
            n = (q1.size() > q0.size()) ? q1.size() : q0.size();
            follow(n);
            stop = 1'b1;
            step();
            stop = 1'b0;
            check_idle($sformatf("rand%0d end", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
